decrypter_stream: RTL and testbench

DECRYPTER_STREAM -- requirements
Module: decrypter_stream

---
 rtl/decrypter_stream.sv | 154 +++++++++++++++
 tb/tb_decrypter_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypter_stream.sv
// Streaming byte decrypter: two-stage valid/ready pipeline with a key-swap FSM
// and a per-message length counter driven by the 0x00 terminator.
module decrypter_stream #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       key_in,
    input  logic             key_load,
    output logic             key_ok,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             msg_done,
    output logic [CNT_W-1:0] msg_len
);

    typedef enum logic [1:0] {StIdle, StActive, StLoad} stateT;

    stateT            stateQ, stateD;
    logic [7:0]       keyQ, keyD;
    logic [7:0]       pendKeyQ, pendKeyD;
    logic             s1ValidQ;
    logic [7:0]       s1DataQ;
    logic [7:0]       s1KeyQ;
    logic             s2ValidQ;
    logic [7:0]       s2DataQ;
    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] msgLenQ;
    logic             msgDoneQ;

    logic inReady;
    logic pipeEmpty;
    logic s2Load;
    logic accept;
    logic handoff;
    logic isTerm;

    // Cipher 0x00 is passed through untouched so it always terminates a message.
    function automatic logic [7:0] decodeByte(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] p;
        p = c ^ k;
        if (c == 8'h00) begin
            return 8'h00;
        end
        return {p[7], ~p[6], p[3], ~p[4], p[1], ~p[2], p[5], ~p[0]};
    endfunction

    assign pipeEmpty = !s1ValidQ && !s2ValidQ;
    assign s2Load    = !s2ValidQ || out_ready;
    assign accept    = in_valid && inReady;
    assign handoff   = s2ValidQ && out_ready;
    assign isTerm    = (s2DataQ == 8'h00);

    always_comb begin
        stateD   = stateQ;
        keyD     = keyQ;
        pendKeyD = pendKeyQ;
        inReady  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (key_load) begin
                    keyD   = key_in;
                    stateD = StActive;
                end
            end
            StActive: begin
                if (key_load) begin
                    if (pipeEmpty) begin
                        keyD = key_in;
                    end else begin
                        pendKeyD = key_in;
                        stateD   = StLoad;
                    end
                end else begin
                    inReady = !(s1ValidQ && s2ValidQ && !out_ready);
                end
            end
            StLoad: begin
                // Bytes already in flight keep their own key; swap only once drained.
                if (pipeEmpty) begin
                    keyD   = pendKeyQ;
                    stateD = StActive;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            keyQ     <= 8'h00;
            pendKeyQ <= 8'h00;
        end else begin
            stateQ   <= stateD;
            keyQ     <= keyD;
            pendKeyQ <= pendKeyD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1ValidQ <= 1'b0;
            s1DataQ  <= 8'h00;
            s1KeyQ   <= 8'h00;
            s2ValidQ <= 1'b0;
            s2DataQ  <= 8'h00;
        end else begin
            if (s2Load) begin
                s2ValidQ <= s1ValidQ;
                if (s1ValidQ) begin
                    s2DataQ <= decodeByte(s1DataQ, s1KeyQ);
                end
            end
            if (accept) begin
                s1ValidQ <= 1'b1;
                s1DataQ  <= in_data;
                s1KeyQ   <= keyQ;
            end else if (s2Load) begin
                s1ValidQ <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cntQ     <= '0;
            msgLenQ  <= '0;
            msgDoneQ <= 1'b0;
        end else begin
            msgDoneQ <= handoff && isTerm;
            if (handoff) begin
                if (isTerm) begin
                    msgLenQ <= cntQ;
                    cntQ    <= '0;
                end else if (cntQ != {CNT_W{1'b1}}) begin
                    cntQ <= cntQ + CNT_W'(1);
                end
            end
        end
    end

    assign key_ok    = (stateQ == StActive);
    assign in_ready  = inReady;
    assign out_data  = s2DataQ;
    assign out_valid = s2ValidQ;
    assign msg_done  = msgDoneQ;
    assign msg_len   = msgLenQ;

endmodule

// File: tb/tb_decrypter_stream.sv
// Directed bench for decrypter_stream: reset, latency, terminator handling,
// backpressure, key swaps, counter saturation and mid-stream reset.
module tb_decrypter_stream;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    key_in;
    logic          key_load;
    logic          key_ok;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          msg_done;
    logic [CW-1:0] msg_len;

    int            nChecks = 0;
    int            nFails  = 0;
    logic [7:0]    got[$];
    int            doneCnt = 0;
    logic [CW-1:0] lastLen = '0;
    int            nAcc    = 0;

    decrypter_stream #(.CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_in   (key_in),
        .key_load (key_load),
        .key_ok   (key_ok),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .msg_done (msg_done),
        .msg_len  (msg_len)
    );

    always #5 clk = ~clk;

    // Logs hand-offs just before the edge, msg_done just after it.
    task automatic cyc();
        #1;
        if (in_valid && in_ready) nAcc++;
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clk);
        #1;
        if (msg_done) begin
            doneCnt++;
            lastLen = msg_len;
        end
    endtask

    task automatic clearLog();
        got.delete();
        doneCnt = 0;
        nAcc    = 0;
    endtask

    task automatic doReset();
        reset = 1'b1; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key_in = 8'h00; in_data = 8'h00;
        cyc(); cyc();
        reset = 1'b0;
        clearLog();
    endtask

    task automatic loadKey(input logic [7:0] k);
        key_in = k; key_load = 1'b1;
        cyc();
        key_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_load = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        key_in = 8'h33; in_data = 8'h14;
        cyc(); cyc();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        nChecks++; if (msg_done !== 1'b0) begin nFails++; $display("FAIL reset_msg_done got %b exp 0", msg_done); end
        nChecks++; if (key_ok !== 1'b0) begin nFails++; $display("FAIL reset_key_ok got %b exp 0", key_ok); end
        nChecks++; if (out_data !== 8'h00) begin nFails++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        nChecks++; if (msg_len !== 3'd0) begin nFails++; $display("FAIL reset_msg_len got %0d exp 0", msg_len); end
        reset = 1'b0;
        cyc();
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL idle_in_ready got %b exp 0", in_ready); end
        nChecks++; if (key_ok !== 1'b0) begin nFails++; $display("FAIL idle_key_ok got %b exp 0", key_ok); end
        in_valid = 1'b0;
    endtask

    task automatic test_latency();
        doReset();
        loadKey(8'h5A);
        nChecks++; if (key_ok !== 1'b1) begin nFails++; $display("FAIL lat_key_ok got %b exp 1", key_ok); end
        out_ready = 1'b1; in_data = 8'h4E; in_valid = 1'b1;
        #1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL lat_in_ready got %b exp 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL lat_early_valid got %b exp 0", out_valid); end
        cyc();
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL lat_out_valid got %b exp 1", out_valid); end
        nChecks++; if (out_data !== 8'h41) begin nFails++; $display("FAIL lat_out_data got %h exp 41", out_data); end
        cyc();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL lat_dup_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_terminator();
        doReset();
        loadKey(8'h00);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h14; cyc();
        in_data = 8'h00; cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        nChecks++; if (got.size() !== 2) begin nFails++; $display("FAIL term_count got %0d exp 2", got.size()); end
        nChecks++; if (got[0] !== 8'h41) begin nFails++; $display("FAIL term_byte0 got %h exp 41", got[0]); end
        nChecks++; if (got[1] !== 8'h00) begin nFails++; $display("FAIL term_byte1 got %h exp 00", got[1]); end
        nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL term_done_pulses got %0d exp 1", doneCnt); end
        nChecks++; if (lastLen !== 3'd1) begin nFails++; $display("FAIL term_msg_len got %0d exp 1", lastLen); end
    endtask

    task automatic test_lone_terminator();
        clearLog();
        in_valid = 1'b1; in_data = 8'h00; cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        nChecks++; if (got.size() !== 1) begin nFails++; $display("FAIL lone_count got %0d exp 1", got.size()); end
        nChecks++; if (got[0] !== 8'h00) begin nFails++; $display("FAIL lone_byte got %h exp 00", got[0]); end
        nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL lone_done_pulses got %0d exp 1", doneCnt); end
        nChecks++; if (msg_len !== 3'd0) begin nFails++; $display("FAIL lone_msg_len got %0d exp 0", msg_len); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[4];
        logic [7:0] e[4];
        int sent;
        int fellAt;
        logic acc;
        b = '{8'h14, 8'h01, 8'h02, 8'h08};
        e = '{8'h41, 8'h54, 8'h5D, 8'h75};
        doReset();
        loadKey(8'h00);
        out_ready = 1'b0;
        sent = 0; fellAt = -1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (sent < 4);
            in_data  = (sent < 4) ? b[sent] : 8'h00;
            #1;
            if (!in_ready && fellAt < 0) fellAt = sent;
            if (i >= 2) begin
                nChecks++;
                if (out_valid !== 1'b1 || out_data !== 8'h41) begin
                    nFails++; $display("FAIL bp_hold cycle %0d got %b/%h exp 1/41", i, out_valid, out_data);
                end
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) sent++;
        end
        nChecks++; if (fellAt !== 2) begin nFails++; $display("FAIL bp_ready_fall got %0d exp 2", fellAt); end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && got.size() < 4; i++) begin
            in_valid = (sent < 4);
            in_data  = (sent < 4) ? b[sent] : 8'h00;
            #1;
            acc = in_valid && in_ready;
            cyc();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        nChecks++; if (got.size() !== 4) begin nFails++; $display("FAIL bp_count got %0d exp 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (got[i] !== e[i]) begin nFails++; $display("FAIL bp_order idx %0d got %h exp %h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_key_swap_inflight();
        int waited;
        doReset();
        loadKey(8'h5A);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h4E; cyc(); cyc();
        in_valid = 1'b0; key_in = 8'h11; key_load = 1'b1;
        #1;
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL swap_req_ready got %b exp 0", in_ready); end
        cyc();
        key_load = 1'b0; key_in = 8'h77;
        nChecks++; if (key_ok !== 1'b0) begin nFails++; $display("FAIL swap_load_key_ok got %b exp 0", key_ok); end
        in_valid = 1'b1; in_data = 8'h05;
        waited = 0;
        while (waited < 10) begin
            #1;
            if (in_ready) break;
            cyc();
            waited++;
        end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL swap_resume got %b exp 1", in_ready); end
        nChecks++; if (got.size() !== 2) begin nFails++; $display("FAIL swap_drained got %0d exp 2", got.size()); end
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        nChecks++; if (got.size() !== 3) begin nFails++; $display("FAIL swap_count got %0d exp 3", got.size()); end
        nChecks++; if (got[0] !== 8'h41) begin nFails++; $display("FAIL swap_old0 got %h exp 41", got[0]); end
        nChecks++; if (got[1] !== 8'h41) begin nFails++; $display("FAIL swap_old1 got %h exp 41", got[1]); end
        nChecks++; if (got[2] !== 8'h41) begin nFails++; $display("FAIL swap_new got %h exp 41", got[2]); end
    endtask

    task automatic test_key_swap_idle();
        key_in = 8'h5A; key_load = 1'b1; in_valid = 1'b1; in_data = 8'h4E;
        #1;
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL swapi_ready got %b exp 0", in_ready); end
        cyc();
        key_load = 1'b0;
        nChecks++; if (key_ok !== 1'b1) begin nFails++; $display("FAIL swapi_key_ok got %b exp 1", key_ok); end
        clearLog();
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        nChecks++; if (got.size() !== 1) begin nFails++; $display("FAIL swapi_count got %0d exp 1", got.size()); end
        nChecks++; if (got[0] !== 8'h41) begin nFails++; $display("FAIL swapi_byte got %h exp 41", got[0]); end
    endtask

    task automatic test_back_to_back();
        int sent;
        int cycles;
        logic acc;
        doReset();
        loadKey(8'h00);
        out_ready = 1'b1;
        sent = 0; cycles = 0;
        while (sent < 10 && cycles < 30) begin
            in_valid = 1'b1;
            in_data  = (sent < 9) ? 8'h14 : 8'h00;
            #1;
            acc = in_ready;
            cyc();
            cycles++;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        nChecks++; if (cycles !== 10) begin nFails++; $display("FAIL b2b_cycles got %0d exp 10", cycles); end
        nChecks++; if (got.size() !== 10) begin nFails++; $display("FAIL b2b_count got %0d exp 10", got.size()); end
        nChecks++; if (got[9] !== 8'h00) begin nFails++; $display("FAIL b2b_last got %h exp 00", got[9]); end
        nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL b2b_done_pulses got %0d exp 1", doneCnt); end
        nChecks++; if (lastLen !== 3'd7) begin nFails++; $display("FAIL b2b_sat_len got %0d exp 7", lastLen); end
    endtask

    task automatic test_mid_reset();
        doReset();
        loadKey(8'h5A);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h4E; cyc();
        in_data = 8'h00; cyc();
        reset = 1'b1; in_valid = 1'b0;
        doneCnt = 0;
        cyc();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL mrst_out_valid got %b exp 0", out_valid); end
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL mrst_in_ready got %b exp 0", in_ready); end
        nChecks++; if (key_ok !== 1'b0) begin nFails++; $display("FAIL mrst_key_ok got %b exp 0", key_ok); end
        reset = 1'b0;
        repeat (4) cyc();
        nChecks++; if (doneCnt !== 0) begin nFails++; $display("FAIL mrst_done got %0d exp 0", doneCnt); end
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL mrst_ghost got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_terminator();
        test_lone_terminator();
        test_backpressure();
        test_key_swap_inflight();
        test_key_swap_idle();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
